// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed little-endian byte image, writes it into
// instruction memory, then releases cpu_reset. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W        = 10,
  parameter int DEPTH         = 1024,
  parameter int RELEASE_DELAY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_HDR0, S_HDR1, S_DATA, S_WRITE, S_CKSUM, S_RELEASE, S_DONE, S_ERROR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_HDR0, S_HDR1, S_DATA, S_WRITE, S_RELEASE, S_DONE, S_ERROR
  } state_t;
`endif

  localparam logic [31:0] DEPTH_U    = 32'(DEPTH);
  localparam logic [3:0]  DELAY_LAST = 4'(RELEASE_DELAY - 1);

  state_t              state_q, state_d;
  logic [15:0]         count_q, count_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic [31:0]         shift_q, shift_d;
  logic [3:0]          delay_q, delay_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [7:0]          cksum_q, cksum_d;

  logic        accept;
  logic [15:0] hdr_n;
  logic        last_word;

  assign accept    = byte_valid && byte_ready;
  assign hdr_n     = {byte_data, count_q[7:0]};
  assign last_word = (32'(word_idx_q) + 32'd1) == 32'(count_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_HDR0;
      count_q    <= '0;
      byte_idx_q <= '0;
      word_idx_q <= '0;
      shift_q    <= '0;
      delay_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cksum_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      shift_q    <= shift_d;
      delay_q    <= delay_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cksum_q    <= cksum_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    byte_idx_d = byte_idx_q;
    word_idx_d = word_idx_q;
    shift_d    = shift_q;
    delay_d    = delay_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cksum_d    = cksum_q;
    case (state_q)
      S_HDR0: begin
        if (accept) begin
          count_d = {8'h00, byte_data};
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          count_d    = hdr_n;
          byte_idx_d = '0;
          word_idx_d = '0;
          cksum_d    = '0;
          if (hdr_n == 16'd0 || 32'(hdr_n) > DEPTH_U) state_d = S_ERROR;
          else                                        state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          // Bytes enter at the top so byte 0 ends up in [7:0] after four shifts.
          shift_d    = {byte_data, shift_q[31:8]};
          byte_idx_d = byte_idx_q + 2'd1;
          cksum_d    = cksum_q ^ byte_data;
          if (byte_idx_q == 2'd3) begin
            addr_d  = word_idx_q;
            wdata_d = {byte_data, shift_q[31:8]};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_q + ADDR_W'(1);
        delay_d    = '0;
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CKSUM;
`else
          state_d = S_RELEASE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CKSUM: begin
        if (accept) begin
          delay_d = '0;
          state_d = (byte_data == cksum_q) ? S_RELEASE : S_ERROR;
        end
      end
`endif
      S_RELEASE: begin
        delay_d = delay_q + 4'd1;
        if (delay_q == DELAY_LAST) state_d = S_DONE;
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_ready = (state_q == S_HDR0) || (state_q == S_HDR1) || (state_q == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (state_q == S_CKSUM) byte_ready = 1'b1;
`endif
    imem_we    = (state_q == S_WRITE);
    imem_addr  = addr_q;
    imem_wdata = wdata_q;
    cpu_reset  = (state_q != S_DONE);
    load_done  = (state_q == S_DONE);
    load_error = (state_q == S_ERROR);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a monitor pops them.
module tb_imem_loader;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;
  localparam int RD     = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready, imem_we, cpu_reset, load_done, load_error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RELEASE_DELAY(RD)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .load_done(load_done),
    .load_error(load_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int last_we_cycle = 0;
  logic [7:0]  stream_q[$];
  logic [31:0] word_q[$];
  int          exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  initial forever begin
    @(negedge clk);
    if (!reset && imem_we) begin
      last_we_cycle = cycle;
      check("ready_low_in_write", 32'(byte_ready), 32'd0);
      if (exp_addr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual_addr=0x%0h required=none", imem_addr);
      end else begin
        check("write_addr", 32'(imem_addr), 32'(exp_addr_q.pop_front()));
        check("write_data", imem_wdata, exp_data_q.pop_front());
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_byte_ready"}, 32'(byte_ready), 32'd1);
    check({tag, "_imem_we"},    32'(imem_we),    32'd0);
    check({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
    check({tag, "_imem_wdata"}, imem_wdata,      32'd0);
    check({tag, "_cpu_reset"},  32'(cpu_reset),  32'd1);
    check({tag, "_load_done"},  32'(load_done),  32'd0);
    check({tag, "_load_error"}, 32'(load_error), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference stream: header, little-endian word bytes, optional XOR trailer.
  task automatic make_stream(input int n_hdr, input int n_words, input logic [7:0] ck_flip);
    logic [7:0] x;
    logic [31:0] w;
    x = 8'h00;
    stream_q.delete();
    stream_q.push_back(8'(n_hdr % 256));
    stream_q.push_back(8'(n_hdr / 256));
    for (int i = 0; i < n_words; i++) begin
      w = word_q[i];
      for (int b = 0; b < 4; b++) begin
        stream_q.push_back(8'((w >> (8 * b)) & 32'hFF));
        x = x ^ 8'((w >> (8 * b)) & 32'hFF);
      end
      exp_addr_q.push_back(i);
      exp_data_q.push_back(w);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (n_words > 0) stream_q.push_back(x ^ ck_flip);
`else
    if (ck_flip != 8'h00) x = 8'h00;
`endif
  endtask

  task automatic random_words(input int n);
    word_q.delete();
    for (int i = 0; i < n; i++) word_q.push_back($urandom);
  endtask

  // mode 0: continuous valid, 1: toggle each cycle, 2: random gaps
  task automatic send_bytes(input int mode);
    int idx = 0;
    int budget = 0;
    int tog = 0;
    logic rdy;
    while (idx < stream_q.size() && budget < 20000) begin
      @(negedge clk);
      rdy = byte_ready;
      tog++;
      case (mode)
        0:       byte_valid = 1'b1;
        1:       byte_valid = (tog % 2) == 1;
        default: byte_valid = $urandom_range(0, 3) != 0;
      endcase
      byte_data = stream_q[idx];
      @(posedge clk);
      if (byte_valid && rdy) idx++;
      budget++;
    end
    #1 byte_valid = 1'b0;
    if (budget >= 20000) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=%0d bytes required=%0d", idx, stream_q.size());
    end
  endtask

  task automatic finish_load(input bit exp_err, input bit check_lat);
    int t = 0;
    @(negedge clk);
    while (!load_done && !load_error && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("load_done",  32'(load_done),  32'(!exp_err));
    check("load_error", 32'(load_error), 32'(exp_err));
    check("cpu_reset",  32'(cpu_reset),  32'(exp_err));
    check("ready_terminal", 32'(byte_ready), 32'd0);
    if (!exp_err && check_lat)
      check("release_latency", 32'(cycle - last_we_cycle), 32'(RD + 1));
    check("pending_writes", 32'(exp_addr_q.size()), 32'd0);
    // Terminal states must refuse further bytes and stay put.
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    repeat (5) @(negedge clk);
    byte_valid = 1'b0;
    check("terminal_hold_ready", 32'(byte_ready), 32'd0);
    check("terminal_hold_done",  32'(load_done),  32'(!exp_err));
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b0;

    // Directed two-word image.
    stream_q = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream_q.push_back(8'h13 ^ 8'h05 ^ 8'h93 ^ 8'h05 ^ 8'h10);
`endif
    exp_addr_q.push_back(0); exp_data_q.push_back(32'h00000513);
    exp_addr_q.push_back(1); exp_data_q.push_back(32'h00100593);
    send_bytes(0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    finish_load(1'b0, 1'b0);
`else
    finish_load(1'b0, 1'b1);
`endif

    // N=0 and N=DEPTH+1 are rejected after the header.
    do_reset();
    word_q.delete();
    make_stream(0, 0, 8'h00);
    send_bytes(0);
    finish_load(1'b1, 1'b0);
    do_reset();
    make_stream(DEPTH + 1, 0, 8'h00);
    send_bytes(0);
    finish_load(1'b1, 1'b0);

    // N=DEPTH fills the whole memory.
    do_reset();
    random_words(DEPTH);
    make_stream(DEPTH, DEPTH, 8'h00);
    send_bytes(0);
    finish_load(1'b0, 1'b0);

    // N=1 with valid toggling every cycle.
    do_reset();
    random_words(1);
    make_stream(1, 1, 8'h00);
    send_bytes(1);
    finish_load(1'b0, 1'b0);

    // Asynchronous reset after 6 of 8 image bytes.
    do_reset();
    random_words(2);
    make_stream(2, 2, 8'h00);
    while (stream_q.size() > 8) void'(stream_q.pop_back());
    send_bytes(0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_reset_vals("async_rst");
    check("async_rst_pending", 32'(exp_addr_q.size()), 32'd1);
    exp_addr_q.delete();
    exp_data_q.delete();
    @(negedge clk);
    reset = 1'b0;
    random_words(1);
    make_stream(1, 1, 8'h00);
    send_bytes(0);
    finish_load(1'b0, 1'b0);

    // Randomized images with random source gaps.
    for (int r = 0; r < 6; r++) begin
      do_reset();
      n = $urandom_range(1, 8);
      random_words(n);
      make_stream(n, n, 8'h00);
      send_bytes(2);
      finish_load(1'b0, 1'b0);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset();
    word_q.delete();
    word_q.push_back(32'hAABBCCDD);
    make_stream(1, 1, 8'h00);
    check("ck_trailer_zero", 32'(stream_q[6]), 32'h00);
    send_bytes(0);
    finish_load(1'b0, 1'b0);
    do_reset();
    make_stream(1, 1, 8'h01);
    send_bytes(0);
    finish_load(1'b1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the pipelined CPU's instruction memory, which the fetch stage reads.
- Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them to consecutive instruction-memory addresses.
- Holds cpu_top in reset until the image is loaded, then releases it.
- Sits between the board/bench byte source and cpu_top's instruction memory and reset input.

Parameters:
- ADDR_W, 10, word-address width of instruction memory.
- DEPTH, 1024, maximum words accepted; must be <= 2**ADDR_W.
- RELEASE_DELAY, 4, cycles between the last write and cpu_reset deassertion; range 1..15.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- byte_valid  in  1  source presents byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader can accept a byte; transfer occurs when byte_valid && byte_ready.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  instruction word.
- cpu_reset  out  1  active-high reset to cpu_top.
- load_done  out  1  image loaded and CPU released.
- load_error  out  1  bad header (or checksum); CPU held in reset.

Behaviour:
- Reset values (reset is asynchronous, active-high): state=HDR0, byte_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, load_done=0, load_error=0, internal counters=0.
- Stream format: word count N as 16-bit little-endian (2 bytes), then 4*N image bytes. Byte 0 of each word maps to [7:0] and byte 3 to [31:24].
- States:
  - HDR0: accept byte -> N[7:0]; go to HDR1.
  - HDR1: accept byte -> N[15:8]. If N==0 or N>DEPTH, go to ERROR; else go to DATA with byte index=0 and word index=0.
  - DATA: accept bytes into the shift register. On the 4th byte, go to WRITE.
  - WRITE: exactly one cycle with imem_we=1, imem_addr=word index, imem_wdata=assembled word. Word index increments. If the written word was word N-1, go to RELEASE (delay counter=0); else return to DATA.
  - RELEASE: counter increments each cycle. When counter==RELEASE_DELAY-1, go to DONE.
  - DONE: cpu_reset=0, load_done=1. Terminal until reset; all further stream bytes are refused.
  - ERROR: load_error=1, cpu_reset=1. Terminal until reset.
- byte_ready=1 only in HDR0, HDR1 and DATA; it is 0 in WRITE, RELEASE, DONE and ERROR. byte_ready is a registered function of state and does not depend on byte_valid.
- Latency:
  - The 4th byte of a word accepted at edge k produces imem_we high during cycle k+1.
  - The earliest next byte is accepted at edge k+2.
  - cpu_reset falls RELEASE_DELAY cycles after the final WRITE cycle. load_done rises in the same cycle.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- byte_valid low in any accepting state: hold, no progress, no timeout.
- Addresses wrap only by construction: N<=DEPTH guarantees imem_addr never exceeds DEPTH-1.
- Reset asserted mid-load (any state): immediately return to reset values and restart the header. Memory contents already written are not cleared.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - One extra byte follows the image: the XOR of all 4*N image bytes (header excluded).
  - After the last WRITE, enter CKSUM with byte_ready=1.
  - Match -> RELEASE. Mismatch -> ERROR.
- Undefined: no CKSUM state; the last WRITE goes directly to RELEASE.

Test Plan:
- Header 0x02,0x00, then bytes 13 05 00 00 93 05 10 00, continuous valid -> writes addr0=0x00000513 and addr1=0x00100593. cpu_reset falls 4 cycles after the 2nd write; load_done=1; load_error=0.
- Header 0x00,0x00 -> ERROR: load_error=1, cpu_reset stays 1, byte_ready=0, no imem_we.
- Header N=1025 (0x01,0x04) with DEPTH=1024 -> ERROR, no writes. Header N=1024 is accepted.
- N=1 with byte_valid toggling 1/0 each cycle -> a single write of the correct word, no duplicated or dropped bytes. byte_ready=0 during the WRITE cycle.
- Reset asserted after 6 of 8 image bytes -> outputs return to reset values asynchronously. A fresh N=1 stream then writes addr0 correctly.
- With IMEM_LOADER_CHECKSUM_EN: N=1, word 0xAABBCCDD, checksum 0x00 -> DONE. Checksum 0x01 -> ERROR with cpu_reset=1.
